// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the two-master Avalon-MM arbiter in front of the SDRAM controller port.
package sdram_arb_pkg;

    localparam int ADDR_W  = 22;
    localparam int DATA_W  = 16;
    localparam int BURST_W = 9;
    localparam int BE_W    = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_CMD   = 2'd2,
        RD_DATA  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  address;
        logic [BURST_W-1:0] burstcount;
        logic [BE_W-1:0]    byteenable;
        logic               write;
        logic [DATA_W-1:0]  writedata;
        logic               read;
    } avm_cmd_t;

    // A zero burstcount is served as a single beat.
    function automatic logic [BURST_W-1:0] burst_len(input logic [BURST_W-1:0] bc);
        return (bc == {BURST_W{1'b0}}) ? BURST_W'(1) : bc;
    endfunction

endpackage

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin picker: on a tie the master that did not win last time is chosen.
module sdram_arb_rr (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_grant
);

    // Pick the requester; alternate on a simultaneous request.
    always_comb begin
        o_valid = |i_req;
        if (i_req == 2'b11) begin
            o_grant = ~i_last;
        end else if (i_req[1]) begin
            o_grant = 1'b1;
        end else begin
            o_grant = 1'b0;
        end
    end

endmodule

// File: rtl/sdram_avalon_arbiter.sv
// Two-master Avalon-MM burst arbiter: one master owns the controller port for a whole burst
// (all write beats, or a read command plus every returned beat), round-robin between bursts.
module sdram_avalon_arbiter
    import sdram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,

    input  logic [ADDR_W-1:0]  m0_address,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic [BE_W-1:0]    m0_byteenable,
    input  logic               m0_write,
    input  logic [DATA_W-1:0]  m0_writedata,
    input  logic               m0_read,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,

    input  logic [ADDR_W-1:0]  m1_address,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic [BE_W-1:0]    m1_byteenable,
    input  logic               m1_write,
    input  logic [DATA_W-1:0]  m1_writedata,
    input  logic               m1_read,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,

    output logic [ADDR_W-1:0]  s_address,
    output logic [BURST_W-1:0] s_burstcount,
    output logic [BE_W-1:0]    s_byteenable,
    output logic               s_write,
    output logic [DATA_W-1:0]  s_writedata,
    output logic               s_read,
    input  logic               s_waitrequest,
    input  logic [DATA_W-1:0]  s_readdata,
    input  logic               s_readdatavalid
);

    arb_state_t         r_state;
    logic               r_grant;
    logic               r_last;
    logic [BURST_W-1:0] r_beats;

    avm_cmd_t           w_cmd0;
    avm_cmd_t           w_cmd1;
    avm_cmd_t           w_sel;
    logic [1:0]         w_req;
    logic               w_any;
    logic               w_pick;
    logic               w_pick_write;
    logic [BURST_W-1:0] w_pick_bc;
    logic               w_pass_wait;
    logic               w_rdv;

    assign w_cmd0 = {m0_address, m0_burstcount, m0_byteenable, m0_write, m0_writedata, m0_read};
    assign w_cmd1 = {m1_address, m1_burstcount, m1_byteenable, m1_write, m1_writedata, m1_read};
    assign w_req  = {m1_read | m1_write, m0_read | m0_write};

    sdram_arb_rr u_rr (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_valid (w_any),
        .o_grant (w_pick)
    );

    // Write wins over read if a master raises both, so only write and burstcount of the pick matter.
    always_comb begin
        if (w_pick) begin
            w_pick_write = m1_write;
            w_pick_bc    = m1_burstcount;
        end else begin
            w_pick_write = m0_write;
            w_pick_bc    = m0_burstcount;
        end
    end

    // Controller-side mux and per-master response steering; everything is gated by the state so a
    // reset forces the idle values immediately and stray read beats never reach a master.
    always_comb begin
        w_sel        = r_grant ? w_cmd1 : w_cmd0;
        s_address    = w_sel.address;
        s_burstcount = w_sel.burstcount;
        s_byteenable = w_sel.byteenable;
        s_writedata  = w_sel.writedata;
        s_write      = (r_state == WR_BURST) & w_sel.write;
        s_read       = (r_state == RD_CMD) & w_sel.read;
        w_pass_wait  = ((r_state == WR_BURST) || (r_state == RD_CMD)) ? s_waitrequest : 1'b1;
        w_rdv        = (r_state == RD_DATA) & s_readdatavalid;
        m0_waitrequest   = r_grant ? 1'b1 : w_pass_wait;
        m1_waitrequest   = r_grant ? w_pass_wait : 1'b1;
        m0_readdatavalid = w_rdv & ~r_grant;
        m1_readdatavalid = w_rdv & r_grant;
        m0_readdata      = s_readdata;
        m1_readdata      = s_readdata;
    end

    // Transaction FSM: grant held for the whole burst, beat counter stops at 1 on the final beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_beats <= {BURST_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_beats <= burst_len(w_pick_bc);
                        r_state <= w_pick_write ? WR_BURST : RD_CMD;
                    end
                end
                WR_BURST: begin
                    if (s_write && !s_waitrequest) begin
                        if (r_beats <= BURST_W'(1)) begin
                            r_state <= IDLE;
                            r_last  <= r_grant;
                        end else begin
                            r_beats <= r_beats - BURST_W'(1);
                        end
                    end
                end
                RD_CMD: begin
                    if (s_read && !s_waitrequest) begin
                        r_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (s_readdatavalid) begin
                        if (r_beats <= BURST_W'(1)) begin
                            r_state <= IDLE;
                            r_last  <= r_grant;
                        end else begin
                            r_beats <= r_beats - BURST_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// Directed bench for sdram_avalon_arbiter with a behavioural SDRAM controller model
// (random waitrequest, read latency 3..8, memory array).
module tb_sdram_avalon_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [21:0] m0_address, m1_address, s_address;
    logic [8:0]  m0_burstcount, m1_burstcount, s_burstcount;
    logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_write, m1_write, s_write;
    logic [15:0] m0_writedata, m1_writedata, s_writedata;
    logic        m0_read, m1_read, s_read;
    logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic [15:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid, s_readdatavalid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] mem [0:4095];
    logic [15:0] rq[$];
    logic [21:0] wlog[$];
    int          wr_total = 0;

    int mon_rdv0, mon_rdv1, mon_both, mon_w1low, mon_last0, mon_first1;

    sdram_avalon_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_byteenable(m0_byteenable),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_read(m0_read),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_byteenable(m1_byteenable),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_read(m1_read),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_burstcount(s_burstcount), .s_byteenable(s_byteenable),
        .s_write(s_write), .s_writedata(s_writedata), .s_read(s_read),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to order events between masters.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_m(input int m, input logic [21:0] a, input logic [8:0] bc,
                         input logic wr, input logic [15:0] wd, input logic rd);
        if (m == 0) begin
            m0_address = a; m0_burstcount = bc; m0_byteenable = 2'b11;
            m0_write = wr; m0_writedata = wd; m0_read = rd;
        end else begin
            m1_address = a; m1_burstcount = bc; m1_byteenable = 2'b11;
            m1_write = wr; m1_writedata = wd; m1_read = rd;
        end
    endtask

    function automatic logic wait_of(input int m);
        return (m == 0) ? m0_waitrequest : m1_waitrequest;
    endfunction

    function automatic logic rdv_of(input int m);
        return (m == 0) ? m0_readdatavalid : m1_readdatavalid;
    endfunction

    function automatic logic [15:0] rd_of(input int m);
        return (m == 0) ? m0_readdata : m1_readdata;
    endfunction

    // Master write burst: beat i carries d0+i.
    task automatic mwrite(input int m, input logic [21:0] a, input logic [8:0] bc, input logic [15:0] d0);
        int   n = (bc == 9'd0) ? 1 : int'(bc);
        int   i = 0;
        int   t = 0;
        logic acc;
        set_m(m, a, bc, 1'b1, d0, 1'b0);
        while (i < n && t < 4000) begin
            @(negedge clk);
            acc = !wait_of(m);
            @(posedge clk); #1;
            if (acc) begin
                i++;
                set_m(m, a, bc, (i < n), d0 + 16'(i), 1'b0);
            end
            t++;
        end
        set_m(m, a, bc, 1'b0, 16'h0000, 1'b0);
        check($sformatf("wr_beats_m%0d_%0h", m, a), i, n);
    endtask

    // Master read burst: expects beat k to be d0+k.
    task automatic mread(input int m, input logic [21:0] a, input logic [8:0] bc, input logic [15:0] d0);
        int   n = (bc == 9'd0) ? 1 : int'(bc);
        int   k = 0;
        int   t = 0;
        logic acc = 1'b0;
        set_m(m, a, bc, 1'b0, 16'h0000, 1'b1);
        while (!acc && t < 4000) begin
            @(negedge clk);
            acc = !wait_of(m);
            @(posedge clk); #1;
            t++;
        end
        set_m(m, a, bc, 1'b0, 16'h0000, 1'b0);
        while (k < n && t < 8000) begin
            @(negedge clk);
            if (rdv_of(m)) begin
                check($sformatf("rd_data_m%0d_%0h_%0d", m, a, k), rd_of(m), d0 + 16'(k));
                k++;
            end
            t++;
        end
        @(posedge clk); #1;
        check($sformatf("rd_beats_m%0d_%0h", m, a), k, n);
    endtask

    task automatic clear_mon();
        mon_rdv0 = 0; mon_rdv1 = 0; mon_both = 0; mon_w1low = 0; mon_last0 = -1; mon_first1 = -1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Controller model: samples the port mid-cycle, applies accepted beats after the edge.
    initial begin
        logic        acc_w, acc_r;
        logic [21:0] wa, ra, wr_addr, tmp;
        logic [15:0] wd;
        logic [8:0]  wbc, rbc;
        int          wr_left = 0;
        int          rd_delay = 0;
        int          n;
        s_waitrequest = 1'b1; s_readdatavalid = 1'b0; s_readdata = 16'h0000; wr_addr = 22'd0;
        forever begin
            @(negedge clk);
            acc_w = s_write && !s_waitrequest;
            acc_r = s_read && !s_waitrequest;
            wa = s_address; wd = s_writedata; wbc = s_burstcount;
            ra = s_address; rbc = s_burstcount;
            @(posedge clk); #1;
            if (acc_w) begin
                if (wr_left == 0) begin
                    wr_addr = wa;
                    wr_left = (wbc == 9'd0) ? 1 : int'(wbc);
                    wlog.push_back(wa);
                end
                mem[wr_addr[11:0]] = wd;
                wr_addr = wr_addr + 22'd1;
                wr_left--;
                wr_total++;
            end
            if (acc_r) begin
                n = (rbc == 9'd0) ? 1 : int'(rbc);
                for (int i = 0; i < n; i++) begin
                    tmp = ra + 22'(i);
                    rq.push_back(mem[tmp[11:0]]);
                end
                rd_delay = int'($urandom_range(3, 8));
            end
            if (rd_delay > 0) begin
                rd_delay--;
                s_readdatavalid = 1'b0;
            end else if (rq.size() > 0) begin
                s_readdatavalid = 1'b1;
                s_readdata = rq.pop_front();
            end else begin
                s_readdatavalid = 1'b0;
            end
            s_waitrequest = ($urandom_range(0, 2) == 0);
        end
    end

    // Response monitor on the master side.
    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            if (m0_readdatavalid) begin mon_rdv0++; mon_last0 = cyc; end
            if (m1_readdatavalid) begin mon_rdv1++; if (mon_first1 < 0) mon_first1 = cyc; end
            if (m0_readdatavalid && m1_readdatavalid) mon_both++;
            if (!m1_waitrequest) mon_w1low++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   err;
        int   k;
        int   t;
        logic acc;
        logic [21:0] ea;
        reset_n = 1'b0;
        set_m(0, 22'h000010, 9'd4, 1'b1, 16'h1234, 1'b0);
        set_m(1, 22'h000020, 9'd4, 1'b0, 16'h0000, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_m0_wait", m0_waitrequest, 1);
        check("rst_m1_wait", m1_waitrequest, 1);
        check("rst_s_write", s_write, 0);
        check("rst_s_read", s_read, 0);
        check("rst_m0_rdv", m0_readdatavalid, 0);
        set_m(0, 22'h0, 9'd0, 1'b0, 16'h0, 1'b0);
        set_m(1, 22'h0, 9'd0, 1'b0, 16'h0, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 256-beat write from m0, m1 must stay stalled.
        clear_mon();
        wr_total = 0;
        mwrite(0, 22'h000000, 9'd256, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("t1_beats_accepted", wr_total, 256);
        err = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 16'(i)) err++;
        check("t1_mem", err, 0);
        check("t1_m1_wait_low", mon_w1low, 0);

        // Simultaneous reads right after reset: m0 first, no interleave.
        pulse_reset();
        clear_mon();
        fork
            mread(0, 22'h000010, 9'd8, 16'h0010);
            mread(1, 22'h000040, 9'd8, 16'h0040);
        join
        check("t2_m0_cnt", mon_rdv0, 8);
        check("t2_m1_cnt", mon_rdv1, 8);
        check("t2_both", mon_both, 0);
        check("t2_order", (mon_first1 > mon_last0), 1);

        // Back-to-back burst-4 writes from both masters alternate.
        wlog.delete();
        fork
            for (int j = 0; j < 4; j++) mwrite(0, 22'h000100 + 22'(16 * j), 9'd4, 16'h0100 + 16'(16 * j));
            for (int j = 0; j < 4; j++) mwrite(1, 22'h000200 + 22'(16 * j), 9'd4, 16'h0200 + 16'(16 * j));
        join
        repeat (3) @(posedge clk);
        #1;
        check("t3_bursts", wlog.size(), 8);
        for (int j = 0; j < 8 && j < wlog.size(); j++) begin
            ea = ((j % 2) == 0) ? 22'h000100 : 22'h000200;
            ea = ea + 22'(16 * (j / 2));
            check($sformatf("t3_order_%0d", j), wlog[j], ea);
        end
        err = 0;
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) begin
                if (mem[12'h100 + 12'(16 * j + i)] !== 16'h0100 + 16'(16 * j + i)) err++;
                if (mem[12'h200 + 12'(16 * j + i)] !== 16'h0200 + 16'(16 * j + i)) err++;
            end
        check("t3_mem", err, 0);

        // burstcount 0 read is a single beat, then the arbiter is free again.
        clear_mon();
        mread(0, 22'h000005, 9'd0, 16'h0005);
        repeat (15) @(posedge clk);
        #1;
        check("t4_single_beat", mon_rdv0, 1);
        mread(1, 22'h000006, 9'd1, 16'h0006);

        // Reset in the middle of a read: no further beats reach any master.
        set_m(0, 22'h000020, 9'd8, 1'b0, 16'h0000, 1'b1);
        acc = 1'b0; t = 0;
        while (!acc && t < 4000) begin
            @(negedge clk);
            acc = !m0_waitrequest;
            @(posedge clk); #1;
            t++;
        end
        set_m(0, 22'h000020, 9'd8, 1'b0, 16'h0000, 1'b0);
        k = 0;
        while (k < 3 && t < 8000) begin
            @(negedge clk);
            if (m0_readdatavalid) k++;
            t++;
        end
        check("t5_pre_beats", k, 3);
        @(negedge clk);
        while (!s_readdatavalid && t < 8000) begin
            @(negedge clk);
            t++;
        end
        #1 reset_n = 1'b0;
        #1;
        check("t5_rst_rdv0", m0_readdatavalid, 0);
        check("t5_rst_wait0", m0_waitrequest, 1);
        check("t5_rst_s_read", s_read, 0);
        clear_mon();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        mwrite(1, 22'h000300, 9'd4, 16'h3300);
        repeat (20) @(posedge clk);
        #1;
        check("t5_late_rdv0", mon_rdv0, 0);
        check("t5_late_rdv1", mon_rdv1, 0);
        err = 0;
        for (int i = 0; i < 4; i++) if (mem[12'h300 + 12'(i)] !== 16'h3300 + 16'(i)) err++;
        check("t5_m1_mem", err, 0);

        // Full-size write then read-back from m0.
        clear_mon();
        mwrite(0, 22'h000400, 9'd256, 16'hA000);
        mread(0, 22'h000400, 9'd256, 16'hA000);
        check("t6_m0_cnt", mon_rdv0, 256);
        check("t6_m1_cnt", mon_rdv1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
